// File: rtl/apb_rr_master_ctrl_pkg.sv
// Shared types and constants for the round-robin APB master controller.
// Holds the latched transfer record and the FSM state encodings.
package apb_rr_master_ctrl_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
        logic [3:0]        strb;
        logic [2:0]        prot;
    } apb_req_t;

endpackage

// File: rtl/apb_rr_master_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above the
// pointer (wrapping) wins; returns a one-hot grant and its index.
module apb_rr_master_ctrl_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_any && i_req[wrap_idx(i_ptr, k)]) begin
                o_any = 1'b1;
                o_idx = wrap_idx(i_ptr, k);
            end
        end
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_rr_master_ctrl.sv
// APB master shared by NREQ requesters: round-robin grant, SETUP/ACCESS
// sequencing with a wait-state timeout, one registered response pulse per transfer.
module apb_rr_master_ctrl #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                i_pclk,
    input  logic                i_preset,
    input  logic [NREQ-1:0]     i_req_valid,
    output logic [NREQ-1:0]     o_req_ready,
    input  logic [NREQ-1:0]     i_req_write,
    input  logic [NREQ*32-1:0]  i_req_addr,
    input  logic [NREQ*32-1:0]  i_req_wdata,
    input  logic [NREQ*4-1:0]   i_req_strb,
    input  logic [NREQ*3-1:0]   i_req_prot,
    output logic [NREQ-1:0]     o_rsp_valid,
    output logic [31:0]         o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_rsp_timeout,
    output logic                o_psel,
    output logic                o_penable,
    output logic                o_pwrite,
    output logic [31:0]         o_paddr,
    output logic [31:0]         o_pwdata,
    output logic [3:0]          o_pstrb,
    output logic [2:0]          o_pprot,
    input  logic [31:0]         i_prdata,
    input  logic                i_pready,
    input  logic                i_pslverr
);
    import apb_rr_master_ctrl_pkg::*;

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    apb_req_t        w_req_fields [NREQ];
    apb_req_t        w_sel;
    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_gnt_idx;
    logic [IW-1:0]   w_ptr_next;
    logic            w_any;

    logic [1:0]      r_state;
    logic [IW-1:0]   r_ptr;
    logic [NREQ-1:0] r_gnt;
    apb_req_t        r_req;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_psel;
    logic            r_penable;
    logic [NREQ-1:0] r_rsp_valid;
    logic [31:0]     r_rsp_rdata;
    logic            r_rsp_err;
    logic            r_rsp_timeout;

    // Reads carry zero strobes and zero write data so the bus never shows stale values.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_req_fields[gi] = {
                i_req_write[gi],
                i_req_addr[gi*APB_AW +: APB_AW],
                i_req_write[gi] ? i_req_wdata[gi*APB_DW +: APB_DW] : {APB_DW{1'b0}},
                i_req_write[gi] ? i_req_strb[gi*4 +: 4] : 4'b0000,
                i_req_prot[gi*3 +: 3]
            };
        end
    endgenerate

    apb_rr_master_ctrl_rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gnt_idx),
        .o_any   (w_any)
    );

    assign w_sel      = w_req_fields[w_gnt_idx];
    assign w_ptr_next = (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + IW'(1);

    assign o_req_ready = (r_state == ST_IDLE && !i_preset) ? w_grant : '0;

    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_gnt         <= '0;
            r_req         <= '0;
            r_wait_cnt    <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_req   <= w_sel;
                        r_gnt   <= w_grant;
                        r_ptr   <= w_ptr_next;
                        r_psel  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready takes precedence over the timeout on the limit cycle.
                    if (i_pready) begin
                        r_rsp_rdata   <= r_req.write ? 32'h0 : i_prdata;
                        r_rsp_err     <= i_pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= r_gnt;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_rdata   <= 32'h0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= r_gnt;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_psel        = r_psel;
    assign o_penable     = r_penable;
    assign o_pwrite      = r_req.write;
    assign o_paddr       = r_req.addr;
    assign o_pwdata      = r_req.wdata;
    assign o_pstrb       = r_req.strb;
    assign o_pprot       = r_req.prot;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_rr_master_ctrl.sv
// Directed bench for apb_rr_master_ctrl (NREQ=4, TIMEOUT=8): each task drives
// one scenario and checks outputs against hand-computed values.
module tb_apb_rr_master_ctrl;

    logic         clk = 1'b0;
    logic         preset;
    logic [3:0]   req_valid, req_ready, req_write, rsp_valid;
    logic [127:0] req_addr, req_wdata;
    logic [15:0]  req_strb;
    logic [11:0]  req_prot;
    logic [31:0]  rsp_rdata, paddr, pwdata, prdata;
    logic         rsp_err, rsp_timeout, psel, penable, pwrite, pready, pslverr;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_rr_master_ctrl #(.NREQ(4), .TIMEOUT(8)) dut (
        .i_pclk        (clk),
        .i_preset      (preset),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_write   (req_write),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .i_req_strb    (req_strb),
        .i_req_prot    (req_prot),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_rsp_timeout (rsp_timeout),
        .o_psel        (psel),
        .o_penable     (penable),
        .o_pwrite      (pwrite),
        .o_paddr       (paddr),
        .o_pwdata      (pwdata),
        .o_pstrb       (pstrb),
        .o_pprot       (pprot),
        .i_prdata      (prdata),
        .i_pready      (pready),
        .i_pslverr     (pslverr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        req_write[i]       = wr;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
        req_strb[i*4 +: 4]    = s;
        req_prot[i*3 +: 3]    = p;
    endtask

    task automatic wait_ready(input int max_cycles);
        int n = 0;
        while (req_ready == 4'b0000 && n < max_cycles) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        preset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
        step(); step();
        total++; if (psel !== 1'b0) begin bad++; $display("FAIL rst_psel got=%0h exp=0", psel); end
        total++; if (penable !== 1'b0) begin bad++; $display("FAIL rst_penable got=%0h exp=0", penable); end
        total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL rst_rsp_valid got=%0h exp=0", rsp_valid); end
        total++; if (paddr !== 32'h0) begin bad++; $display("FAIL rst_paddr got=%0h exp=0", paddr); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata got=%0h exp=0", rsp_rdata); end
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL rst_req_ready got=%0h exp=0", req_ready); end
        preset = 1'b0;
        step();
        $display("reset released");
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
        req_valid = 4'b0001; pready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wr_ready got=%0h exp=1", req_ready); end
        step(); req_valid = 4'b0000;
        total++; if ({psel, penable} !== 2'b10) begin bad++; $display("FAIL wr_setup got=%0b exp=10", {psel, penable}); end
        total++; if (paddr !== 32'h10) begin bad++; $display("FAIL wr_paddr got=%0h exp=10", paddr); end
        total++; if ({pwrite, pstrb, pprot} !== {1'b1, 4'hF, 3'b010}) begin bad++; $display("FAIL wr_ctrl got=%0h exp=%0h", {pwrite, pstrb, pprot}, {1'b1, 4'hF, 3'b010}); end
        total++; if (pwdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_pwdata got=%0h exp=deadbeef", pwdata); end
        step();
        total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL wr_access got=%0b exp=11", {psel, penable}); end
        step();
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL wr_rsp_valid got=%0h exp=1", rsp_valid); end
        total++; if ({rsp_err, rsp_timeout} !== 2'b00) begin bad++; $display("FAIL wr_rsp_err got=%0b exp=00", {rsp_err, rsp_timeout}); end
        total++; if (psel !== 1'b0) begin bad++; $display("FAIL wr_psel_low got=%0h exp=0", psel); end
        total++; if (paddr !== 32'h10) begin bad++; $display("FAIL wr_paddr_hold got=%0h exp=10", paddr); end
        $display("txn req0 write addr=%0h done err=%0b", paddr, rsp_err);
        step();
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL wr_rsp_pulse got=%0h exp=0", rsp_valid); end
    endtask

    task automatic test_read_wait();
        set_req(2, 1'b0, 32'h20, 32'h55555555, 4'hF, 3'b001);
        req_valid = 4'b0100; pready = 1'b0; prdata = 32'hBAD0BAD0;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rd_ready got=%0h exp=4", req_ready); end
        step(); req_valid = 4'b0000;
        total++; if ({pwrite, pstrb} !== 5'b0_0000) begin bad++; $display("FAIL rd_setup_strb got=%0h exp=0", {pwrite, pstrb}); end
        total++; if (pwdata !== 32'h0) begin bad++; $display("FAIL rd_pwdata got=%0h exp=0", pwdata); end
        total++; if (paddr !== 32'h20) begin bad++; $display("FAIL rd_paddr got=%0h exp=20", paddr); end
        step();
        for (int i = 0; i < 3; i++) begin
            total++; if ({psel, penable, rsp_valid} !== 6'b11_0000) begin bad++; $display("FAIL rd_wait%0d got=%0h exp=30", i, {psel, penable, rsp_valid}); end
            step();
        end
        pready = 1'b1; prdata = 32'h12345678;
        #1;
        total++; if ({penable, pstrb} !== 5'b1_0000) begin bad++; $display("FAIL rd_access_strb got=%0h exp=10", {penable, pstrb}); end
        step();
        total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL rd_rsp_valid got=%0h exp=4", rsp_valid); end
        total++; if (rsp_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_rdata got=%0h exp=12345678", rsp_rdata); end
        $display("txn req2 read rdata=%0h err=%0b", rsp_rdata, rsp_err);
        prdata = 32'h0;
    endtask

    task automatic test_round_robin();
        logic [3:0] prev_grant;
        logic [3:0] exp_grant;
        preset = 1'b1; #1; step(); preset = 1'b0; step();
        prev_grant = 4'b0000;
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, 32'h100 + 32'(k), 32'(k), 4'hF, 3'b000);
        req_valid = 4'b1111; pready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_ready(10);
            exp_grant = 4'b0001 << (k % 4);
            total++; if (req_ready !== exp_grant) begin bad++; $display("FAIL rr_grant%0d got=%0h exp=%0h", k, req_ready, exp_grant); end
            total++; if (rsp_valid !== prev_grant) begin bad++; $display("FAIL rr_rsp%0d got=%0h exp=%0h", k, rsp_valid, prev_grant); end
            $display("txn rr grant=%0h", req_ready);
            prev_grant = exp_grant;
            step();
        end
        req_valid = 4'b1000;
        wait_ready(10);
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL rr_only3 got=%0h exp=8", req_ready); end
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL rr_rsp_last got=%0h exp=1", rsp_valid); end
        step(); req_valid = 4'b0000;
        step(); step();
        total++; if (rsp_valid !== 4'b1000) begin bad++; $display("FAIL rr_rsp3 got=%0h exp=8", rsp_valid); end
        $display("txn req3 done rsp_valid=%0h", rsp_valid);
    endtask

    task automatic test_timeout();
        set_req(1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'h3, 3'b000);
        req_valid = 4'b0010; pready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL to_ready got=%0h exp=2", req_ready); end
        step(); req_valid = 4'b0000;
        step();
        for (int i = 0; i < 8; i++) begin
            total++; if ({psel, penable, rsp_valid} !== 6'b11_0000) begin bad++; $display("FAIL to_access%0d got=%0h exp=30", i, {psel, penable, rsp_valid}); end
            step();
        end
        total++; if (psel !== 1'b0) begin bad++; $display("FAIL to_psel_low got=%0h exp=0", psel); end
        total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL to_rsp_valid got=%0h exp=2", rsp_valid); end
        total++; if ({rsp_err, rsp_timeout} !== 2'b11) begin bad++; $display("FAIL to_err got=%0b exp=11", {rsp_err, rsp_timeout}); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata got=%0h exp=0", rsp_rdata); end
        $display("txn req1 write timeout=%0b", rsp_timeout);
        pready = 1'b1;
        step();
    endtask

    task automatic test_slverr_and_limit();
        set_req(0, 1'b1, 32'h80, 32'h11112222, 4'hC, 3'b100);
        req_valid = 4'b0001; pready = 1'b1; pslverr = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL se_ready got=%0h exp=1", req_ready); end
        step(); req_valid = 4'b0000;
        step(); step();
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL se_rsp_valid got=%0h exp=1", rsp_valid); end
        total++; if ({rsp_err, rsp_timeout} !== 2'b10) begin bad++; $display("FAIL se_err got=%0b exp=10", {rsp_err, rsp_timeout}); end
        $display("txn req0 write slverr err=%0b", rsp_err);
        pslverr = 1'b0;
        set_req(2, 1'b0, 32'hC0, 32'h0, 4'hF, 3'b000);
        req_valid = 4'b0100; pready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL lim_ready got=%0h exp=4", req_ready); end
        step(); req_valid = 4'b0000;
        step();
        for (int i = 0; i < 7; i++) step();
        pready = 1'b1; prdata = 32'hCAFEF00D;
        step();
        total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL lim_rsp_valid got=%0h exp=4", rsp_valid); end
        total++; if ({rsp_err, rsp_timeout} !== 2'b00) begin bad++; $display("FAIL lim_err got=%0b exp=00", {rsp_err, rsp_timeout}); end
        total++; if (rsp_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL lim_rdata got=%0h exp=cafef00d", rsp_rdata); end
        $display("txn req2 read at limit rdata=%0h", rsp_rdata);
        prdata = 32'h0;
    endtask

    task automatic test_reset_mid_access();
        set_req(1, 1'b0, 32'h44, 32'h0, 4'h0, 3'b000);
        set_req(3, 1'b0, 32'h4C, 32'h0, 4'h0, 3'b000);
        req_valid = 4'b0010; pready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mr_ready got=%0h exp=2", req_ready); end
        step(); req_valid = 4'b0000;
        step();
        total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL mr_access got=%0b exp=11", {psel, penable}); end
        preset = 1'b1;
        #1;
        total++; if ({psel, penable} !== 2'b00) begin bad++; $display("FAIL mr_async_drop got=%0b exp=00", {psel, penable}); end
        step();
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL mr_no_rsp got=%0h exp=0", rsp_valid); end
        preset = 1'b0;
        step();
        total++; if ({psel, rsp_valid} !== 5'b0_0000) begin bad++; $display("FAIL mr_idle got=%0h exp=0", {psel, rsp_valid}); end
        req_valid = 4'b1010; pready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mr_ptr0 got=%0h exp=2", req_ready); end
        step(); req_valid = 4'b0000;
        step(); step();
        total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL mr_rsp got=%0h exp=2", rsp_valid); end
        $display("txn req1 after reset rsp_valid=%0h", rsp_valid);
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_round_robin();
        test_timeout();
        test_slverr_and_limit();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
